// File: rtl/reg_bank_8x32.sv
// Eight 32-bit signed registers with per-register valid flags, write acknowledge
// and an eight-cycle clear sweep that walks the bank one register per clock.
module reg_bank_8x32 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [2:0]         wr_addr,
  input  logic signed [31:0] wr_data,
  input  logic               clr_req,
  output logic signed [31:0] q0,
  output logic signed [31:0] q1,
  output logic signed [31:0] q2,
  output logic signed [31:0] q3,
  output logic signed [31:0] q4,
  output logic signed [31:0] q5,
  output logic signed [31:0] q6,
  output logic signed [31:0] q7,
  output logic [7:0]         valid,
  output logic [3:0]         valid_cnt,
  output logic               wr_ack,
  output logic               busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [2:0]         sw_idx_r;
  logic [2:0]         sw_idx_nxt_s;
  logic signed [31:0] q_r [8];
  logic [7:0]         valid_r;
  logic [7:0]         valid_nxt_s;
  logic [3:0]         valid_cnt_r;
  logic               wr_ack_r;
  logic               wr_ack_nxt_s;
  logic               busy_r;
  logic [7:0]         q_ld_s;
  logic [7:0]         q_clr_s;

  // valid_cnt is loaded from the next valid vector so both flops agree every cycle.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Next-state, sweep index and per-register load/clear decode.
  always_comb begin
    state_nxt_s  = state_r;
    sw_idx_nxt_s = sw_idx_r;
    valid_nxt_s  = valid_r;
    wr_ack_nxt_s = 1'b0;
    q_ld_s       = 8'h00;
    q_clr_s      = 8'h00;
    case (state_r)
      IDLE: begin
        if (clr_req) begin
          // A clear request beats a simultaneous write; the write is dropped.
          state_nxt_s  = SWEEP;
          sw_idx_nxt_s = 3'd0;
        end else if (wr_en) begin
          q_ld_s[wr_addr]      = 1'b1;
          valid_nxt_s[wr_addr] = 1'b1;
          wr_ack_nxt_s         = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SWEEP: begin
        q_clr_s[sw_idx_r]     = 1'b1;
        valid_nxt_s[sw_idx_r] = 1'b0;
        if (sw_idx_r == 3'd7) begin
          state_nxt_s  = IDLE;
          sw_idx_nxt_s = 3'd0;
        end else begin
          sw_idx_nxt_s = sw_idx_r + 3'd1;
        end
      end
      default: begin
        state_nxt_s  = IDLE;
        sw_idx_nxt_s = 3'd0;
      end
    endcase
  end

  // Control and status flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sw_idx_r    <= 3'd0;
      valid_r     <= 8'h00;
      valid_cnt_r <= 4'd0;
      wr_ack_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sw_idx_r    <= sw_idx_nxt_s;
      valid_r     <= valid_nxt_s;
      valid_cnt_r <= popcount8(valid_nxt_s);
      wr_ack_r    <= wr_ack_nxt_s;
      busy_r      <= (state_nxt_s == SWEEP);
    end
  end

  // Register file storage; data is kept bit-for-bit as written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        q_r[i] <= 32'sd0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (q_ld_s[i]) begin
          q_r[i] <= wr_data;
        end else if (q_clr_s[i]) begin
          q_r[i] <= 32'sd0;
        end else begin
          q_r[i] <= q_r[i];
        end
      end
    end
  end

  assign q0        = q_r[0];
  assign q1        = q_r[1];
  assign q2        = q_r[2];
  assign q3        = q_r[3];
  assign q4        = q_r[4];
  assign q5        = q_r[5];
  assign q6        = q_r[6];
  assign q7        = q_r[7];
  assign valid     = valid_r;
  assign valid_cnt = valid_cnt_r;
  assign wr_ack    = wr_ack_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_reg_bank_8x32.sv
// Directed bench for reg_bank_8x32: expected outputs are queued as stimulus is
// applied and compared against the DUT one cycle later.
module tb_reg_bank_8x32;

  logic               clk;
  logic               rst_n;
  logic               wr_en;
  logic [2:0]         wr_addr;
  logic signed [31:0] wr_data;
  logic               clr_req;
  logic signed [31:0] q0, q1, q2, q3, q4, q5, q6, q7;
  logic [7:0]         valid;
  logic [3:0]         valid_cnt;
  logic               wr_ack;
  logic               busy;

  reg_bank_8x32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .clr_req   (clr_req),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
    .q3        (q3),
    .q4        (q4),
    .q5        (q5),
    .q6        (q6),
    .q7        (q7),
    .valid     (valid),
    .valid_cnt (valid_cnt),
    .wr_ack    (wr_ack),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_q [8];
  logic [7:0]  m_valid;
  int          n_checks;
  int          n_pass;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      0:       return q0;
      1:       return q1;
      2:       return q2;
      3:       return q3;
      4:       return q4;
      5:       return q5;
      6:       return q6;
      7:       return q7;
      8:       return {24'd0, valid};
      9:       return {28'd0, valid_cnt};
      10:      return {31'd0, wr_ack};
      11:      return {31'd0, busy};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push_state(input string ctx, input logic ack, input logic bsy);
    for (int i = 0; i < 8; i++) begin
      sb.push_back('{i, m_q[i], $sformatf("%s.q%0d", ctx, i)});
    end
    sb.push_back('{8, {24'd0, m_valid}, {ctx, ".valid"}});
    sb.push_back('{9, 32'($countones(m_valid)), {ctx, ".valid_cnt"}});
    sb.push_back('{10, {31'd0, ack}, {ctx, ".wr_ack"}});
    sb.push_back('{11, {31'd0, bsy}, {ctx, ".busy"}});
  endtask

  task automatic check_sb();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      n_checks++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_q[i] = 32'd0;
    m_valid = 8'h00;
  endtask

  task automatic write_step(input string ctx, input logic [2:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en      = 1'b0;
    m_q[a]     = d;
    m_valid[a] = 1'b1;
    push_state(ctx, 1'b1, 1'b0);
    check_sb();
  endtask

  logic [31:0] vals [8];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    vals = '{32'hFFFF_FFF4, 32'd120, 32'd1034, 32'd2234,
             32'hFFFF_FFF3, 32'd123, 32'd1024, 32'd2034};
    wr_en   = 1'b0;
    wr_addr = 3'd0;
    wr_data = 32'sd0;
    clr_req = 1'b0;
    rst_n   = 1'b1;
    clear_model();

    // Reset acts before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    push_state("reset", 1'b0, 1'b0);
    check_sb();
    #9 rst_n = 1'b1;
    step();
    push_state("idle_after_reset", 1'b0, 1'b0);
    check_sb();

    // Fill the bank on consecutive cycles; every cycle must carry an ack.
    for (int i = 0; i < 8; i++) begin
      write_step($sformatf("fill%0d", i), 3'(i), vals[i]);
    end
    step();
    push_state("fill_done", 1'b0, 1'b0);
    check_sb();

    // Full sweep: busy for 8 cycles, register n cleared on sweep cycle n.
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    push_state("sweep_start", 1'b0, 1'b1);
    check_sb();
    for (int n = 0; n < 8; n++) begin
      step();
      m_q[n]     = 32'd0;
      m_valid[n] = 1'b0;
      push_state($sformatf("sweep%0d", n), 1'b0, (n < 7));
      check_sb();
    end

    // Writes and clr_req during a sweep are ignored.
    write_step("pre_ign5", 3'd5, 32'd77);
    write_step("pre_ign1", 3'd1, 32'd11);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    push_state("ign_start", 1'b0, 1'b1);
    check_sb();
    for (int n = 0; n < 8; n++) begin
      wr_en   = 1'b1;
      wr_addr = 3'd5;
      wr_data = 32'sd999;
      clr_req = (n == 3);
      step();
      m_q[n]     = 32'd0;
      m_valid[n] = 1'b0;
      push_state($sformatf("ign%0d", n), 1'b0, (n < 7));
      check_sb();
    end
    wr_en   = 1'b0;
    clr_req = 1'b0;
    step();
    push_state("ign_after", 1'b0, 1'b0);
    check_sb();

    // Simultaneous clear and write: the write is dropped.
    write_step("pre_prio3", 3'd3, 32'd33);
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 32'sd55;
    clr_req = 1'b1;
    step();
    wr_en   = 1'b0;
    clr_req = 1'b0;
    push_state("prio_start", 1'b0, 1'b1);
    check_sb();
    for (int n = 0; n < 8; n++) begin
      step();
      m_q[n]     = 32'd0;
      m_valid[n] = 1'b0;
      push_state($sformatf("prio%0d", n), 1'b0, (n < 7));
      check_sb();
    end

    // Overwriting a valid register keeps the count.
    write_step("rw_pos", 3'd2, 32'd7);
    write_step("rw_neg", 3'd2, 32'hFFFF_FFF9);

    // Reset in the middle of a sweep aborts it.
    write_step("pre_abort0", 3'd0, 32'd5);
    write_step("pre_abort7", 3'd7, 32'hFFFF_FFFF);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    push_state("abort_start", 1'b0, 1'b1);
    check_sb();
    for (int n = 0; n < 4; n++) begin
      step();
      m_q[n]     = 32'd0;
      m_valid[n] = 1'b0;
      push_state($sformatf("abort%0d", n), 1'b0, 1'b1);
      check_sb();
    end
    rst_n = 1'b0;
    #2;
    clear_model();
    push_state("abort_reset", 1'b0, 1'b0);
    check_sb();
    #1;
    rst_n   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 3'd6;
    wr_data = 32'sd66;
    step();
    wr_en      = 1'b0;
    m_q[6]     = 32'd66;
    m_valid[6] = 1'b1;
    push_state("post_abort_wr", 1'b1, 1'b0);
    check_sb();
    step();
    push_state("post_abort_idle", 1'b0, 1'b0);
    check_sb();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bank_8x32.md
REG_BANK_8X32 -- requirements
Module: reg_bank_8x32

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have port wr_en, input, 1 bit: write request, sampled on rising clk.
REQ-004 The block SHALL have port wr_addr, input, 3 bits: target register index 0..7.
REQ-005 The block SHALL have port wr_data, input, 32 bits, signed: write data.
REQ-006 The block SHALL have port clr_req, input, 1 bit: start a clear sweep.
REQ-007 The block SHALL have ports q0..q7, outputs, 32 bits signed each: register contents, driven directly from flops. These ports feed I0..I7 of the downstream 8-to-1 selector.
REQ-008 The block SHALL have port valid, output, 8 bits: bit n is 1 when register n holds written data.
REQ-009 The block SHALL have port valid_cnt, output, 4 bits: population count of valid, range 0..8.
REQ-010 The block SHALL have port wr_ack, output, 1 bit: one-cycle pulse confirming an accepted write.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a clear sweep is in progress.

Function
REQ-012 The block SHALL have two states: IDLE and SWEEP, plus a 3-bit sweep counter sw_idx.
REQ-013 In IDLE with clr_req=1, the block SHALL enter SWEEP on the next edge with sw_idx=0 and busy=1.
REQ-014 Priority in IDLE with clr_req=1 and wr_en=1 in the same cycle: clr_req SHALL win, the write SHALL be dropped, and no wr_ack SHALL be produced.
REQ-015 On each SWEEP cycle, the block SHALL clear q[sw_idx] to 0 and valid[sw_idx] to 0, then increment sw_idx.
REQ-016 The sweep SHALL run for exactly 8 cycles: on the edge that clears index 7, the state SHALL return to IDLE and busy SHALL fall.
REQ-017 sw_idx SHALL not wrap past 7 inside a single sweep.
REQ-018 In SWEEP, wr_en SHALL be ignored, no register other than q[sw_idx] SHALL change, and wr_ack SHALL stay 0.
REQ-019 In SWEEP, clr_req SHALL be ignored and SHALL not restart or extend the sweep.
REQ-020 In IDLE with wr_en=1 and clr_req=0, the edge SHALL load q[wr_addr] with wr_data and set valid[wr_addr]=1.
REQ-021 For the write in REQ-020, wr_ack SHALL be 1 for exactly the following cycle; one write SHALL produce one ack.
REQ-022 Back-to-back writes on consecutive cycles SHALL all be accepted, with wr_ack held high on each following cycle.
REQ-023 Rewriting an already-valid register SHALL overwrite its data and leave valid_cnt unchanged.
REQ-024 valid_cnt SHALL be registered and consistent with valid in the same cycle; it SHALL never exceed 8.
REQ-025 All data SHALL be stored unmodified as 32-bit two's complement, with no sign or width conversion.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force: q0..q7=0, valid=8'h00, valid_cnt=0, wr_ack=0, busy=0, state=IDLE, sw_idx=0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL be in IDLE and SHALL not resume the sweep.
REQ-028 On the first edge after rst_n rises, the block SHALL accept a write, or a clr_req, normally.

Verification
REQ-029 Reset, then write -12,120,1034,2234,-13,123,1024,2034 to addr 0..7 on consecutive cycles -> q0..q7 match, valid=8'hFF, valid_cnt=8, eight consecutive wr_ack pulses.
REQ-030 From the full state, pulse clr_req -> busy high for 8 cycles; q[n] reads 0 after sweep cycle n; valid ends 8'h00 and valid_cnt ends 0.
REQ-031 Same cycle wr_en=1 (addr 3, data 55) and clr_req=1 -> no wr_ack; after the sweep, q3=0 and valid[3]=0.
REQ-032 Writes to addr 5 during SWEEP -> q5 ends 0 and wr_ack stays 0; clr_req during SWEEP -> sweep length stays 8.
REQ-033 Write addr 2 = 7, then addr 2 = -7 -> q2=-7 and valid_cnt stays 1.
REQ-034 Assert rst_n=0 at sweep cycle 4 -> all outputs 0 immediately; after release, busy=0 and a write to addr 6 is acked normally.
